alu_seq: RTL and testbench

// - Parametrised multi-cycle successor to the datapath ALU: W-bit operands, valid/ready handshake on

---
 rtl/alu_seq.sv | 146 ++++++++++++++
 tb/tb_alu_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle W-bit ALU with valid/ready handshake and a 1-bit/cycle iterative shifter.
// Define ALU_SEQ_ROTATE_EN to enable ROL/ROR on opcodes 0110/0111.
module alu_seq #(
    parameter int unsigned W   = 8,
    parameter int unsigned SHW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sc_i,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] rslt,
    output logic         sc_o,
    output logic         pari,
    output logic         zero,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   rslt_q, rslt_d;
    logic           sc_q, sc_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic           left_q, left_d;
    logic           rot_q, rot_d;
    logic           bne_q, bne_d;
    logic           taken_q, taken_d;

    logic           accept;
    logic           load_shift, load_left, load_rot;
    logic [W-1:0]   load_val;
    logic           load_sc;
    logic [W:0]     sum;
    logic           fill;

    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept   = in_valid && in_ready;
    assign sum      = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, sc_i};

    // Decode the incoming request and its immediate (non-iterative) result.
    always_comb begin
        load_shift = 1'b0;
        load_left  = 1'b0;
        load_rot   = 1'b0;
        case (op_i)
            4'b1010: begin load_shift = 1'b1; load_left = 1'b1; end
            4'b1011: load_shift = 1'b1;
`ifdef ALU_SEQ_ROTATE_EN
            4'b0110: begin load_shift = 1'b1; load_left = 1'b1; load_rot = 1'b1; end
            4'b0111: begin load_shift = 1'b1; load_rot = 1'b1; end
`endif
            default: ;
        endcase

        load_val = '0;
        load_sc  = 1'b0;
        case (op_i[3:1])
            3'b000:  {load_sc, load_val} = sum;
            3'b001:  load_val = b_i;
            3'b010:  load_val = a_i ^ b_i;
            3'b110:  load_val = op_i[0] ? b_i : '0;
            3'b111:  load_val = a_i & b_i;
            default: load_val = '0;
        endcase
        if (load_shift) begin
            load_val = a_i;
            load_sc  = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        rslt_d  = rslt_q;
        sc_d    = sc_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        rot_d   = rot_q;
        bne_d   = bne_q;
        taken_d = taken_q;
        fill    = rot_q ? (left_q ? rslt_q[W-1] : rslt_q[0]) : 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    rslt_d  = load_val;
                    sc_d    = load_sc;
                    cnt_d   = load_shift ? b_i[SHW-1:0] : '0;
                    left_d  = load_left;
                    rot_d   = load_rot;
                    bne_d   = (op_i == 4'b1100);
                    taken_d = |a_i;
                    state_d = (load_shift && (b_i[SHW-1:0] != '0)) ? StShift : StDone;
                end else if (state_q == StDone && out_ready) begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                if (left_q) begin
                    {sc_d, rslt_d} = {rslt_q, fill};
                end else begin
                    {rslt_d, sc_d} = {fill, rslt_q};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rslt_q  <= '0;
            sc_q    <= 1'b0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            rot_q   <= 1'b0;
            bne_q   <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rslt_q  <= rslt_d;
            sc_q    <= sc_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            rot_q   <= rot_d;
            bne_q   <= bne_d;
            taken_q <= taken_d;
        end
    end

    assign rslt      = rslt_q;
    assign sc_o      = sc_q;
    assign pari      = ^rslt_q;
    // BNE reports the branch-taken flag instead of the zero test of its (always zero) result.
    assign zero      = bne_q ? taken_q : ~|rslt_q;
    assign out_valid = (state_q == StDone);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases plus randomized ops against a behavioural model.
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int unsigned W   = 8;
    localparam int unsigned SHW = $clog2(W);

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   op_i = '0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         sc_i = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] rslt;
    logic         sc_o;
    logic         pari;
    logic         zero;
    logic         out_valid;
    logic         out_ready = 1'b1;

    alu_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .sc_i      (sc_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rslt      (rslt),
        .sc_o      (sc_o),
        .pari      (pari),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         p;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   bp_mode = 0;  // 0: always ready, 1: random backpressure, 2: stalled
    logic seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference model straight from the opcode table; shifts/rotates via double-width arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic c);
        exp_t         e;
        logic [2*W-1:0] wl, wr;
        logic [W:0]   s;
        int           k;
        k  = int'(b[SHW-1:0]);
        wl = {{W{1'b0}}, a} << k;
        wr = {a, {W{1'b0}}} >> k;
        s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.r = '0; e.c = 1'b0; e.lat = 1; e.acc = 0;
        casez (op)
            4'b000?: begin e.r = s[W-1:0]; e.c = s[W]; end
            4'b001?: e.r = b;
            4'b010?: e.r = a ^ b;
            4'b111?: e.r = a & b;
            4'b1010: begin e.r = wl[W-1:0]; e.c = (k != 0) && wl[W]; e.lat = k + 1; end
            4'b1011: begin e.r = wr[2*W-1:W]; e.c = (k != 0) && wr[W-1]; e.lat = k + 1; end
            4'b1101: e.r = b;
`ifdef ALU_SEQ_ROTATE_EN
            4'b0110: begin
                e.r = wl[W-1:0] | wl[2*W-1:W]; e.c = (k != 0) && e.r[0]; e.lat = k + 1;
            end
            4'b0111: begin
                e.r = wr[2*W-1:W] | wr[W-1:0]; e.c = (k != 0) && e.r[W-1]; e.lat = k + 1;
            end
`endif
            default: ;
        endcase
        e.z = (op == 4'b1100) ? |a : ~|e.r;
        e.p = ^e.r;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: checks every presented result against the queue head, pops on retire.
    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_out_valid");
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                    seen = 1'b1;
                end
                chk("rslt", 32'(rslt), 32'(sb[0].r));
                chk("sc_o", 32'(sc_o), 32'(sb[0].c));
                chk("zero", 32'(zero), 32'(sb[0].z));
                chk("pari", 32'(pari), 32'(sb[0].p));
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Call at #1 after a rising edge; returns #1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
        exp_t e;
        int   t;
        e = model(op, a, b, c);
        op_i = op; a_i = a; b_i = b; sc_i = c; in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.acc = cyc + 1;
                sb.push_back(e);
                break;
            end
            t++;
            if (t > 4 * W + 50) begin
                fail_now("accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_i = 4'($urandom); a_i = W'($urandom); b_i = W'($urandom); sc_i = 1'($urandom);
    endtask

    task automatic wait_valid(input string nm);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 2 * W + 10) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) fail_now({nm, "_valid_timeout"});
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic c, input logic [W-1:0] xr,
                            input logic xc, input logic xz);
        bp_mode = 2;
        out_ready = 1'b0;
        issue(op, a, b, c);
        wait_valid(nm);
        chk({nm, "_rslt"}, 32'(rslt), 32'(xr));
        chk({nm, "_sc_o"}, 32'(sc_o), 32'(xc));
        chk({nm, "_zero"}, 32'(zero), 32'(xz));
        bp_mode = 0;
        drain();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        seen = 1'b0;
        @(negedge clk);
        chk("rst_rslt", 32'(rslt), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_zero", 32'(zero), 32'h1);
        chk("rst_pari", 32'(pari), 32'h0);
        chk("rst_sc_o", 32'(sc_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        do_reset();

        directed("add", 4'b0000, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0);
        chk("add_pari", 32'(pari), 32'h0);
        directed("shr", 4'b1011, 8'hB5, 8'h03, 1'b0, 8'h16, 1'b1, 1'b0);
        directed("shl0", 4'b1010, 8'h5A, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0);
        directed("shl_hi", 4'b1010, 8'h81, 8'hF9, 1'b0, 8'h02, 1'b1, 1'b0);
        directed("bne0", 4'b1100, 8'h00, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0);
        directed("bne4", 4'b1100, 8'h04, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1);
        directed("rsvd", 4'b1001, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1);
`ifdef ALU_SEQ_ROTATE_EN
        directed("rol", 4'b0110, 8'h81, 8'h01, 1'b0, 8'h03, 1'b1, 1'b0);
`else
        directed("rol_off", 4'b0110, 8'h81, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1);
`endif

        // Backpressure: hold an XOR result, then retire and accept on the same edge.
        bp_mode = 2;
        out_ready = 1'b0;
        issue(4'b0100, 8'h3C, 8'h5A, 1'b0);
        wait_valid("xor");
        repeat (5) begin
            chk("bp_rslt", 32'(rslt), 32'h66);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bp_mode = 0;
        out_ready = 1'b1;
        issue(4'b0011, 8'h00, 8'hA7, 1'b0);
        @(negedge clk);
        chk("b2b_valid", 32'(out_valid), 32'h1);
        chk("b2b_rslt", 32'(rslt), 32'hA7);
        drain();

        // Reset in the middle of a long shift must abort it silently.
        issue(4'b1010, 8'hC3, 8'h07, 1'b0);
        repeat (2) @(posedge clk);
        do_reset();
        repeat (12) begin
            @(negedge clk);
            chk("abort_out_valid", 32'(out_valid), 32'h0);
        end
        @(posedge clk);
        #1;

        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(15)), W'($urandom), W'($urandom), 1'($urandom));
            if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(posedge clk);
            #0;
        end
        bp_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
